quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 124 ++++++++++++
 tb/tb_quad_step_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronizer, per-channel glitch filter, settle window and step/direction generation.
// Define QDEC_X4_EN for x4 decoding (a step on every legal edge); the default build decodes x1.
module quad_step_decoder #(
  parameter int FILT_W   = 3,
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clr_err,
  output logic       step_en,
  output logic       step_up,
  output logic       err,
  output logic [1:0] phase
);

  localparam int SETTLE_INIT = FILT_LEN + 3;
  localparam int SETTLE_W    = $clog2(SETTLE_INIT + 1);
  localparam logic [FILT_W-1:0]   CNT_LAST       = FILT_W'(FILT_LEN - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD    = SETTLE_W'(SETTLE_INIT);

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          filt_q;
  logic [FILT_W-1:0]   cnt_q [2];
  logic [1:0]          prev_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                step_en_q, step_up_q, err_q;
  logic                step_en_d, step_up_d, err_d;
  logic                stepReq, dirUp, illegal, settled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {a_in, b_in};
      sync2_q <= sync1_q;
    end
  end

  // Bit 1 is channel A, bit 0 is channel B; each needs FILT_LEN disagreeing samples to move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_q[ch] == filt_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          filt_q[ch] <= sync2_q[ch];
          cnt_q[ch]  <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  assign illegal = ((prev_q ^ filt_q) == 2'b11);
  assign settled = (settle_q == '0);

`ifdef QDEC_X4_EN
  function automatic logic [1:0] grayPos(input logic [1:0] p);
    case (p)
      2'b00:   grayPos = 2'd0;
      2'b10:   grayPos = 2'd1;
      2'b11:   grayPos = 2'd2;
      default: grayPos = 2'd3;
    endcase
  endfunction

  logic [1:0] posP, posN;
  logic       fwd, bwd;
  assign posP    = grayPos(prev_q);
  assign posN    = grayPos(filt_q);
  assign fwd     = (posN == posP + 2'd1);
  assign bwd     = (posP == posN + 2'd1);
  assign stepReq = fwd | bwd;
  assign dirUp   = fwd;
`else
  assign stepReq = ((prev_q == 2'b00) && (filt_q == 2'b10)) ||
                   ((prev_q == 2'b10) && (filt_q == 2'b00));
  assign dirUp   = (filt_q == 2'b10);
`endif

  // A fresh illegal jump outranks a simultaneous clear; the settle window masks both steps and errors.
  always_comb begin
    step_en_d = stepReq & settled;
    step_up_d = step_en_d ? dirUp : step_up_q;
    err_d     = err_q;
    if (illegal && settled) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      step_en_q <= 1'b0;
      step_up_q <= 1'b0;
      err_q     <= 1'b0;
      settle_q  <= SETTLE_LOAD;
    end else begin
      prev_q    <= filt_q;
      step_en_q <= step_en_d;
      step_up_q <= step_up_d;
      err_q     <= err_d;
      if (!settled) begin
        settle_q <= settle_q - 1'b1;
      end
    end
  end

  assign step_en = step_en_q;
  assign step_up = step_up_q;
  assign err     = err_q;
  assign phase   = prev_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed self-checking bench for quad_step_decoder (FILT_LEN=4); expectations follow QDEC_X4_EN if defined.
module tb_quad_step_decoder;

`ifdef QDEC_X4_EN
  localparam int STEPS_PER_CYCLE = 4;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       aIn = 1'b0;
  logic       bIn = 1'b0;
  logic       clrErr = 1'b0;
  logic       stepEn, stepUp, err;
  logic [1:0] phase;

  int vectorCount = 0;
  int missCount = 0;
  int upTotal = 0;
  int downTotal = 0;

  quad_step_decoder #(.FILT_W(3), .FILT_LEN(4)) dut (
    .clk(clock), .reset(reset), .a_in(aIn), .b_in(bIn), .clr_err(clrErr),
    .step_en(stepEn), .step_up(stepUp), .err(err), .phase(phase)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && stepEn) begin
      if (stepUp) upTotal = upTotal + 1;
      else downTotal = downTotal + 1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] lvl, input int cycles);
    {aIn, bIn} = lvl;
    tick(cycles);
  endtask

  initial begin
    int upBase, downBase, nonZero;
    logic saw10;

    @(negedge clock);
    tick(2);
    checkOutput("rst_step_en", stepEn, 0);
    checkOutput("rst_step_up", stepUp, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_phase", phase, 0);

    reset = 1'b0;
    applyStimulus(2'b00, 20);
    checkOutput("idle_steps", upTotal + downTotal, 0);
    checkOutput("idle_err", err, 0);
    checkOutput("idle_phase", phase, 0);

    // Full up cycle with exact latency check on the first step.
    upBase = upTotal; downBase = downTotal;
    applyStimulus(2'b10, 6);
    checkOutput("up_edge6_en", stepEn, 0);
    tick(1);
    checkOutput("up_edge7_en", stepEn, 1);
    checkOutput("up_edge7_dir", stepUp, 1);
    tick(1);
    checkOutput("up_edge8_en", stepEn, 0);
    tick(2);
    checkOutput("up_phase10", phase, 2);
    applyStimulus(2'b11, 10);
    checkOutput("up_phase11", phase, 3);
    applyStimulus(2'b01, 10);
    checkOutput("up_phase01", phase, 1);
    applyStimulus(2'b00, 10);
    checkOutput("up_phase00", phase, 0);
    checkOutput("up_count", upTotal - upBase, STEPS_PER_CYCLE);
    checkOutput("up_down_count", downTotal - downBase, 0);
    checkOutput("up_err", err, 0);

    // Reverse cycle.
    upBase = upTotal; downBase = downTotal;
    applyStimulus(2'b01, 10);
    applyStimulus(2'b11, 10);
    applyStimulus(2'b10, 10);
    checkOutput("dn_phase10", phase, 2);
    applyStimulus(2'b00, 10);
    checkOutput("dn_count", downTotal - downBase, STEPS_PER_CYCLE);
    checkOutput("dn_up_count", upTotal - upBase, 0);
    checkOutput("dn_phase00", phase, 0);

    // Three-cycle glitch on A is rejected.
    upBase = upTotal; downBase = downTotal;
    nonZero = 0;
    aIn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) aIn = 1'b0;
      tick(1);
      if (phase != 2'b00) nonZero++;
    end
    checkOutput("glitch3_phase", nonZero, 0);
    checkOutput("glitch3_steps", (upTotal - upBase) + (downTotal - downBase), 0);

    // Four-cycle pulse on A is accepted: +1 then -1.
    upBase = upTotal; downBase = downTotal;
    saw10 = 1'b0;
    aIn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) aIn = 1'b0;
      tick(1);
      if (phase == 2'b10) saw10 = 1'b1;
    end
    checkOutput("pulse4_saw10", saw10, 1);
    checkOutput("pulse4_phase", phase, 0);
    checkOutput("pulse4_up", upTotal - upBase, 1);
    checkOutput("pulse4_down", downTotal - downBase, 1);

    // Illegal 00->11, then clear racing a new illegal 11->00, then clear alone.
    upBase = upTotal; downBase = downTotal;
    applyStimulus(2'b11, 10);
    checkOutput("ill_err_set", err, 1);
    checkOutput("ill_phase11", phase, 3);
    applyStimulus(2'b00, 6);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checkOutput("ill_clr_race", err, 1);
    tick(3);
    checkOutput("ill_phase00", phase, 0);
    checkOutput("ill_steps", (upTotal - upBase) + (downTotal - downBase), 0);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checkOutput("ill_clr_alone", err, 0);

    // Resting at 11 through reset release is absorbed by the settle window.
    upBase = upTotal; downBase = downTotal;
    {aIn, bIn} = 2'b11;
    reset = 1'b1;
    tick(1);
    checkOutput("rst11_phase", phase, 0);
    checkOutput("rst11_err", err, 0);
    reset = 1'b0;
    tick(6);
    checkOutput("rst11_phase_e6", phase, 0);
    tick(1);
    checkOutput("rst11_phase_e7", phase, 3);
    checkOutput("rst11_en_e7", stepEn, 0);
    tick(13);
    checkOutput("rst11_err_end", err, 0);
    checkOutput("rst11_steps", (upTotal - upBase) + (downTotal - downBase), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
